// File: rtl/rst_pkg.sv
// Shared types and helpers for the reset sequencer.
// Holds the FSM state encoding, the cause bit positions and the counter width helper.
package rst_pkg;

    typedef enum logic {
        StHold,
        StRun
    } state_e;

    localparam int unsigned CAUSE_PWR = 0;
    localparam int unsigned CAUSE_BTN = 1;
    localparam int unsigned CAUSE_SYS = 2;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce.sv
// Synchroniser followed by a stable-count filter for an active-low, bouncy input.
// The output follows the input only after it has differed for DEBOUNCE_CYCLES cycles in a row.
module debounce
    import rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_n,
    output logic out_db
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   in_s;

    assign in_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        // Any cycle matching the accepted level restarts the count.
        if (in_s != db_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                db_d = in_s;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Reset to the released level so a power-up never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            cnt_q  <= '0;
            db_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_n};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign out_db = db_q;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: merges PLL lock, push-button and system requests into one stretched reset.
// Also records the cause of the last reset and counts warm resets since power-on.
module rst_seq
    import rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned STRETCH_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_ok,
    input  logic       btn_n,
    input  logic       sys_rst_req,
    output logic       rst_out_n,
    output logic [2:0] rst_cause,
    output logic [7:0] rst_count
);

    localparam int unsigned StrW = cnt_width(STRETCH_CYCLES);

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   btn_db;
    logic                   btn_db_prev_q;
    state_e                 state_q, state_d;
    logic [StrW-1:0]        cnt_q, cnt_d;
    logic                   rst_out_q, rst_out_d;
    logic [2:0]             cause_q, cause_d;
    logic [7:0]             count_q, count_d;
    logic                   lock_loss, press, hold_btn, req;

    debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk   (clk),
        .rst_n (rst_n),
        .in_n  (btn_n),
        .out_db(btn_db)
    );

    assign lock_loss = !lock_sync_q[SYNC_STAGES-1];
    assign press     = btn_db_prev_q && !btn_db;
    assign hold_btn  = !btn_db;
    assign req       = sys_rst_req;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out_q;
        cause_d   = cause_q;
        count_d   = count_q;
        unique case (state_q)
            StHold: begin
                rst_out_d = 1'b0;
                // Counting to STRETCH_CYCLES keeps the request-to-release window at
                // STRETCH_CYCLES+1 low cycles, including the cycle the reset is entered.
                if (lock_loss || hold_btn || req) begin
                    cnt_d = '0;
                end else if (cnt_q == StrW'(STRETCH_CYCLES)) begin
                    state_d   = StRun;
                    rst_out_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + StrW'(1);
                end
            end
            StRun: begin
                rst_out_d = 1'b1;
                if (lock_loss || press || req) begin
                    state_d              = StHold;
                    rst_out_d            = 1'b0;
                    cnt_d                = '0;
                    cause_d              = '0;
                    cause_d[CAUSE_PWR]   = lock_loss;
                    cause_d[CAUSE_BTN]   = press;
                    cause_d[CAUSE_SYS]   = req;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q   <= '0;
            btn_db_prev_q <= 1'b1;
            state_q       <= StHold;
            cnt_q         <= '0;
            rst_out_q     <= 1'b0;
            cause_q       <= 3'b001;
            count_q       <= '0;
        end else begin
            lock_sync_q   <= {lock_sync_q[SYNC_STAGES-2:0], clk_ok};
            btn_db_prev_q <= btn_db;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rst_out_q     <= rst_out_d;
            cause_q       <= cause_d;
            count_q       <= count_d;
        end
    end

    assign rst_out_n = rst_out_q;
    assign rst_cause = cause_q;
    assign rst_count = count_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: stimulus queues expected rst_out_n edges with cause, count
// and a cycle window; a monitor pops one entry per observed edge of rst_out_n.
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clk_ok = 1'b1;
    logic       btn_n = 1'b1;
    logic       sys_rst_req = 1'b0;
    logic       rst_out_n;
    logic [2:0] rst_cause;
    logic [7:0] rst_count;

    rst_seq #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .STRETCH_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_ok     (clk_ok),
        .btn_n      (btn_n),
        .sys_rst_req(sys_rst_req),
        .rst_out_n  (rst_out_n),
        .rst_cause  (rst_cause),
        .rst_count  (rst_count)
    );

    typedef struct {
        logic       lvl;
        logic [2:0] cause;
        logic [7:0] count;
        int         lo;
        int         hi;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_lvl = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_out_n !== prev_lvl) begin
                prev_lvl = rst_out_n;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_edge: rst_out_n=%b at cycle %0d, no edge required",
                             rst_out_n, cyc);
                end else begin
                    e = q.pop_front();
                    check("edge_level", {31'd0, rst_out_n}, {31'd0, e.lvl});
                    check("edge_cause", {29'd0, rst_cause}, {29'd0, e.cause});
                    check("edge_count", {24'd0, rst_count}, {24'd0, e.count});
                    total++;
                    if (cyc < e.lo || cyc > e.hi) begin
                        bad++;
                        $display("FAIL edge_time: rst_out_n=%b at cycle %0d, required %0d..%0d",
                                 rst_out_n, cyc, e.lo, e.hi);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic lvl, input logic [2:0] cause, input logic [7:0] count,
                        input int lo, input int hi);
        exp_t e;
        e.lvl   = lvl;
        e.cause = cause;
        e.count = count;
        e.lo    = lo;
        e.hi    = hi;
        q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d edges still pending after %0d cycles, required 0",
                     q.size(), budget);
            q.delete();
        end
    endtask

    initial begin : stim
        int c;
        logic [7:0] n;
        #2;
        // Power-up with lock already present.
        rst_n = 1'b0;
        tick(3);
        check("por_rst_out_n", {31'd0, rst_out_n}, 32'd0);
        check("por_cause", {29'd0, rst_cause}, 32'd1);
        check("por_count", {24'd0, rst_count}, 32'd0);
        rst_n = 1'b1;
        c = cyc;
        push(1'b1, 3'b001, 8'd0, c + 18, c + 20);
        drain(60);

        // Late PLL lock after a fresh rst_n.
        tick(3);
        clk_ok = 1'b0;
        rst_n  = 1'b0;
        c = cyc;
        push(1'b0, 3'b001, 8'd0, c, c + 1);
        #1;
        check("async_rst_out_n", {31'd0, rst_out_n}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(100);
        clk_ok = 1'b1;
        c = cyc;
        push(1'b1, 3'b001, 8'd0, c + 17, c + 20);
        drain(60);

        // Single system request in RUN.
        tick(3);
        c = cyc;
        sys_rst_req = 1'b1;
        push(1'b0, 3'b100, 8'd1, c + 1, c + 1);
        push(1'b1, 3'b100, 8'd1, c + 18, c + 18);
        tick(1);
        sys_rst_req = 1'b0;
        drain(60);

        // Short bounces must not reach the debounced level.
        tick(3);
        repeat (5) begin
            btn_n = 1'b0;
            tick(3);
            btn_n = 1'b1;
            tick(3);
        end
        tick(20);
        check("bounce_no_reset", {31'd0, rst_out_n}, 32'd1);

        // Button held long enough to be accepted, then released.
        c = cyc;
        btn_n = 1'b0;
        push(1'b0, 3'b010, 8'd2, c + 9, c + 13);
        push(1'b1, 3'b010, 8'd2, c + 44, c + 49);
        tick(20);
        btn_n = 1'b1;
        drain(80);

        // Lock loss and request land on the same edge.
        tick(3);
        c = cyc;
        clk_ok = 1'b0;
        push(1'b0, 3'b101, 8'd3, c + 3, c + 3);
        push(1'b1, 3'b101, 8'd3, c + 21, c + 23);
        tick(2);
        sys_rst_req = 1'b1;
        tick(1);
        sys_rst_req = 1'b0;
        clk_ok = 1'b1;
        drain(60);

        // Drive the warm-reset count into saturation.
        for (int i = 1; i <= 260; i++) begin
            tick(1);
            c = cyc;
            n = (3 + i > 255) ? 8'd255 : 8'(3 + i);
            sys_rst_req = 1'b1;
            push(1'b0, 3'b100, n, c + 1, c + 1);
            push(1'b1, 3'b100, n, c + 18, c + 18);
            tick(1);
            sys_rst_req = 1'b0;
            drain(40);
        end
        check("sat_count", {24'd0, rst_count}, 32'd255);

        // rst_n in the middle of a stretch clears the history at once.
        tick(2);
        c = cyc;
        sys_rst_req = 1'b1;
        push(1'b0, 3'b100, 8'd255, c + 1, c + 1);
        tick(1);
        sys_rst_req = 1'b0;
        tick(5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_n", {31'd0, rst_out_n}, 32'd0);
        check("mid_count", {24'd0, rst_count}, 32'd0);
        check("mid_cause", {29'd0, rst_cause}, 32'd1);
        tick(3);
        rst_n = 1'b1;
        c = cyc;
        push(1'b1, 3'b001, 8'd0, c + 18, c + 20);
        drain(60);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
